// File: rtl/pkt_gen_pkg.sv
// Shared types and helpers for the packet-generator token scheduler.
package pkt_gen_pkg;

    typedef enum logic [1:0] {
        ST_SCAN   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_REFILL = 2'd2
    } sched_state_e;

    // Flow-index width: one bit minimum so a single-flow build still has an address.
    function automatic int unsigned flow_w_f(input int unsigned cnt);
        return (cnt <= 1) ? 1 : $clog2(cnt);
    endfunction

    localparam int unsigned FLOW_CNT_DEF = 16;
    localparam int unsigned FLOW_W_DEF   = flow_w_f(FLOW_CNT_DEF);

    typedef logic [FLOW_W_DEF-1:0] flow_num_t;

endpackage

// File: rtl/pkt_gen_tick_gen.sv
// Refill-period counter; raises a pending refill on every wrap and flags ticks lost while one is still pending.
module pkt_gen_tick_gen #(
    parameter int unsigned UPDATE_PERIOD = 100
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic refill_pend_o,
    output logic overrun_o
);

    localparam int unsigned CNT_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pend_q;
    logic             pend_d;
    logic             overrun_q;
    logic             overrun_d;
    logic             wrap;

    // Next count, pending flag and overrun pulse; a tick consumed in the same cycle is not an overrun.
    always_comb begin
        wrap      = (cnt_q == CNT_W'(UPDATE_PERIOD - 1));
        cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
        overrun_d = wrap && pend_q && !clear_i;
        if (wrap) begin
            pend_d = 1'b1;
        end else if (clear_i) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
        end
    end

    assign refill_pend_o = pend_q;
    assign overrun_o     = overrun_q;

endmodule

// File: rtl/pkt_gen_token_scheduler.sv
// Token-bucket scheduler: per-flow byte credit, periodic refill, round-robin task emission.
module pkt_gen_token_scheduler
    import pkt_gen_pkg::*;
#(
    parameter int unsigned  FLOW_CNT      = 16,
    parameter int unsigned  SIZE_W        = 16,
    parameter int unsigned  TOKEN_W       = 32,
    parameter int unsigned  BUCKET_W      = 32,
    parameter int unsigned  UPDATE_PERIOD = 100,
    localparam int unsigned FLOW_W        = flow_w_f(FLOW_CNT)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [FLOW_W-1:0]   wr_size_addr_i,
    input  logic [SIZE_W-1:0]   wr_size_data_i,
    input  logic                wr_size_wr_en_i,
    input  logic [FLOW_W-1:0]   wr_token_addr_i,
    input  logic [TOKEN_W-1:0]  wr_token_data_i,
    input  logic                wr_token_wr_en_i,
    input  logic [FLOW_W-1:0]   wr_flow_en_addr_i,
    input  logic                wr_flow_en_data_i,
    input  logic                wr_flow_en_wr_en_i,
    output logic [FLOW_W-1:0]   task_flow_num_o,
    output logic [SIZE_W-1:0]   task_pkt_size_o,
    output logic                task_valid_o,
    input  logic                task_ready_i,
    output logic                refill_overrun_o
);

    logic [SIZE_W-1:0]   size_q   [FLOW_CNT];
    logic [TOKEN_W-1:0]  token_q  [FLOW_CNT];
    logic [BUCKET_W-1:0] bucket_q [FLOW_CNT];
    logic [FLOW_CNT-1:0] en_q;

    sched_state_e        state_q;
    logic [FLOW_W-1:0]   ptr_q;
    logic [FLOW_W-1:0]   ridx_q;
    logic [FLOW_W-1:0]   flow_q;
    logic [SIZE_W-1:0]   tsize_q;
    logic                valid_q;

    logic                refill_pend;
    logic                refill_start_c;
    logic                eligible_c;
    logic                accept_c;
    logic                refill_hit_c;
    logic [BUCKET_W:0]   refill_sum_c;
    logic [BUCKET_W-1:0] refill_val_c;
    logic [BUCKET_W-1:0] deduct_val_c;

    function automatic logic [FLOW_W-1:0] next_flow(input logic [FLOW_W-1:0] f);
        return (f == FLOW_W'(FLOW_CNT - 1)) ? '0 : f + FLOW_W'(1);
    endfunction

    pkt_gen_tick_gen #(
        .UPDATE_PERIOD (UPDATE_PERIOD)
    ) u_tick (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (refill_start_c),
        .refill_pend_o (refill_pend),
        .overrun_o     (refill_overrun_o)
    );

    // Eligibility of the scanned flow, saturating refill and floor-at-zero deduct.
    always_comb begin
        refill_start_c = (state_q == ST_SCAN) && refill_pend;
        eligible_c     = en_q[ptr_q] && (size_q[ptr_q] != '0)
                         && (bucket_q[ptr_q] >= BUCKET_W'(size_q[ptr_q]));
        accept_c       = (state_q == ST_EMIT) && task_ready_i;
        refill_hit_c   = (state_q == ST_REFILL) && en_q[ridx_q];
        refill_sum_c   = {1'b0, bucket_q[ridx_q]} + (BUCKET_W + 1)'(token_q[ridx_q]);
        refill_val_c   = refill_sum_c[BUCKET_W] ? '1 : refill_sum_c[BUCKET_W-1:0];
        // A flow disabled while its task was offered has an empty bucket; never wrap below zero.
        deduct_val_c   = (bucket_q[flow_q] >= BUCKET_W'(tsize_q))
                         ? bucket_q[flow_q] - BUCKET_W'(tsize_q) : '0;
    end

    // Configuration storage written by the host.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(FLOW_CNT); i++) begin
                size_q[i]  <= '0;
                token_q[i] <= '0;
            end
            en_q <= '0;
        end else begin
            for (int i = 0; i < int'(FLOW_CNT); i++) begin
                if (wr_size_wr_en_i && (wr_size_addr_i == FLOW_W'(i))) begin
                    size_q[i] <= wr_size_data_i;
                end
                if (wr_token_wr_en_i && (wr_token_addr_i == FLOW_W'(i))) begin
                    token_q[i] <= wr_token_data_i;
                end
                if (wr_flow_en_wr_en_i && (wr_flow_en_addr_i == FLOW_W'(i))) begin
                    en_q[i] <= wr_flow_en_data_i;
                end
            end
        end
    end

    // Bucket credit: a disable clear wins over refill and deduct to the same flow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(FLOW_CNT); i++) begin
                bucket_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(FLOW_CNT); i++) begin
                if (wr_flow_en_wr_en_i && !wr_flow_en_data_i && (wr_flow_en_addr_i == FLOW_W'(i))) begin
                    bucket_q[i] <= '0;
                end else if (refill_hit_c && (ridx_q == FLOW_W'(i))) begin
                    bucket_q[i] <= refill_val_c;
                end else if (accept_c && (flow_q == FLOW_W'(i))) begin
                    bucket_q[i] <= deduct_val_c;
                end
            end
        end
    end

    // Scheduler FSM: refill beats scan; an offered task is held until accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_SCAN;
            ptr_q   <= '0;
            ridx_q  <= '0;
            flow_q  <= '0;
            tsize_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_SCAN: begin
                    if (refill_pend) begin
                        state_q <= ST_REFILL;
                        ridx_q  <= '0;
                    end else if (eligible_c) begin
                        flow_q  <= ptr_q;
                        tsize_q <= size_q[ptr_q];
                        valid_q <= 1'b1;
                        state_q <= ST_EMIT;
                    end else begin
                        ptr_q <= next_flow(ptr_q);
                    end
                end
                ST_EMIT: begin
                    if (task_ready_i) begin
                        valid_q <= 1'b0;
                        ptr_q   <= next_flow(flow_q);
                        state_q <= ST_SCAN;
                    end
                end
                ST_REFILL: begin
                    if (ridx_q == FLOW_W'(FLOW_CNT - 1)) begin
                        state_q <= ST_SCAN;
                    end else begin
                        ridx_q <= ridx_q + FLOW_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_SCAN;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign task_flow_num_o = flow_q;
    assign task_pkt_size_o = tsize_q;
    assign task_valid_o    = valid_q;

endmodule

// File: tb/tb_pkt_gen_token_scheduler.sv
// Bench for the token scheduler: cycle model of the scheduling rules, directed scenarios, random traffic.
module tb_pkt_gen_token_scheduler;

    localparam int unsigned FLOW_CNT      = 8;
    localparam int unsigned SIZE_W        = 16;
    localparam int unsigned TOKEN_W       = 32;
    localparam int unsigned BUCKET_W      = 32;
    localparam int unsigned UPDATE_PERIOD = 100;
    localparam int unsigned FLOW_W        = 3;
    localparam longint unsigned BKT_MAX   = (64'd1 << BUCKET_W) - 64'd1;

    localparam int MODE_LOOK  = 0;
    localparam int MODE_OFFER = 1;
    localparam int MODE_FILL  = 2;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [FLOW_W-1:0]  wr_size_addr_i, wr_token_addr_i, wr_flow_en_addr_i;
    logic [SIZE_W-1:0]  wr_size_data_i;
    logic [TOKEN_W-1:0] wr_token_data_i;
    logic               wr_flow_en_data_i;
    logic               wr_size_wr_en_i, wr_token_wr_en_i, wr_flow_en_wr_en_i;
    logic [FLOW_W-1:0]  task_flow_num_o;
    logic [SIZE_W-1:0]  task_pkt_size_o;
    logic               task_valid_o;
    logic               task_ready_i;
    logic               refill_overrun_o;

    pkt_gen_token_scheduler #(
        .FLOW_CNT      (FLOW_CNT),
        .SIZE_W        (SIZE_W),
        .TOKEN_W       (TOKEN_W),
        .BUCKET_W      (BUCKET_W),
        .UPDATE_PERIOD (UPDATE_PERIOD)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .wr_size_addr_i     (wr_size_addr_i),
        .wr_size_data_i     (wr_size_data_i),
        .wr_size_wr_en_i    (wr_size_wr_en_i),
        .wr_token_addr_i    (wr_token_addr_i),
        .wr_token_data_i    (wr_token_data_i),
        .wr_token_wr_en_i   (wr_token_wr_en_i),
        .wr_flow_en_addr_i  (wr_flow_en_addr_i),
        .wr_flow_en_data_i  (wr_flow_en_data_i),
        .wr_flow_en_wr_en_i (wr_flow_en_wr_en_i),
        .task_flow_num_o    (task_flow_num_o),
        .task_pkt_size_o    (task_pkt_size_o),
        .task_valid_o       (task_valid_o),
        .task_ready_i       (task_ready_i),
        .refill_overrun_o   (refill_overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: cycle position in the period, pending refill, what is being offered.
    int              m_tick, m_mode, m_ptr, m_ridx, m_flow;
    bit              m_pend, m_valid, m_over;
    longint unsigned m_size;
    longint unsigned m_sz  [FLOW_CNT];
    longint unsigned m_tok [FLOW_CNT];
    longint unsigned m_bkt [FLOW_CNT];
    bit              m_en  [FLOW_CNT];

    // Observed traffic, cleared per scenario.
    int acc_total, acc_bytes, over_cnt;
    int acc_per_flow [FLOW_CNT];
    int rec_q [$];

    function automatic void model_reset();
        m_tick = 0; m_mode = MODE_LOOK; m_ptr = 0; m_ridx = 0; m_flow = 0;
        m_pend = 0; m_valid = 0; m_over = 0; m_size = 0;
        for (int i = 0; i < FLOW_CNT; i++) begin
            m_sz[i] = 0; m_tok[i] = 0; m_bkt[i] = 0; m_en[i] = 0;
        end
    endfunction

    // Advance the reference by one clock using the inputs currently applied.
    function automatic void model_step();
        longint unsigned nb [FLOW_CNT];
        longint unsigned s;
        bit tick_now, take_refill;
        int n_mode, n_ptr, n_ridx;
        nb = m_bkt;
        n_mode = m_mode; n_ptr = m_ptr; n_ridx = m_ridx;
        tick_now    = (m_tick == UPDATE_PERIOD - 1);
        take_refill = (m_mode == MODE_LOOK) && m_pend;
        m_over = tick_now && m_pend && !take_refill;
        if (tick_now) m_pend = 1;
        else if (take_refill) m_pend = 0;
        m_tick = tick_now ? 0 : m_tick + 1;
        if (m_mode == MODE_LOOK) begin
            if (take_refill) begin
                n_mode = MODE_FILL; n_ridx = 0;
            end else if (m_en[m_ptr] && m_sz[m_ptr] != 0 && m_bkt[m_ptr] >= m_sz[m_ptr]) begin
                m_flow = m_ptr; m_size = m_sz[m_ptr]; m_valid = 1; n_mode = MODE_OFFER;
            end else begin
                n_ptr = (m_ptr + 1) % FLOW_CNT;
            end
        end else if (m_mode == MODE_OFFER) begin
            if (task_ready_i) begin
                nb[m_flow] = (m_bkt[m_flow] >= m_size) ? m_bkt[m_flow] - m_size : 0;
                n_ptr = (m_flow + 1) % FLOW_CNT;
                m_valid = 0; n_mode = MODE_LOOK;
            end
        end else begin
            if (m_en[m_ridx]) begin
                s = m_bkt[m_ridx] + m_tok[m_ridx];
                nb[m_ridx] = (s > BKT_MAX) ? BKT_MAX : s;
            end
            if (m_ridx == FLOW_CNT - 1) n_mode = MODE_LOOK;
            else n_ridx = m_ridx + 1;
        end
        if (wr_size_wr_en_i)  m_sz[int'(wr_size_addr_i)]   = 64'(wr_size_data_i);
        if (wr_token_wr_en_i) m_tok[int'(wr_token_addr_i)] = 64'(wr_token_data_i);
        if (wr_flow_en_wr_en_i) begin
            m_en[int'(wr_flow_en_addr_i)] = wr_flow_en_data_i;
            if (!wr_flow_en_data_i) nb[int'(wr_flow_en_addr_i)] = 0;
        end
        m_bkt = nb; m_mode = n_mode; m_ptr = n_ptr; m_ridx = n_ridx;
    endfunction

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every observable against the reference.
    task automatic check_all();
        int bad;
        chk("valid", 64'(task_valid_o), 64'(m_valid));
        chk("overrun", 64'(refill_overrun_o), 64'(m_over));
        if (m_valid) begin
            chk("flow", 64'(task_flow_num_o), 64'(m_flow));
            chk("size", 64'(task_pkt_size_o), m_size);
        end
        bad = -1;
        for (int i = 0; i < FLOW_CNT; i++)
            if (bad < 0 && 64'(dut.bucket_q[i]) != m_bkt[i]) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL bucket[%0d]: got %0h expected %0h at %0t", bad, dut.bucket_q[bad], m_bkt[bad], $time);
        end
    endtask

    task automatic cycle();
        if (task_valid_o && task_ready_i) begin
            acc_total++;
            acc_bytes += int'(task_pkt_size_o);
            acc_per_flow[task_flow_num_o]++;
            rec_q.push_back(int'(task_flow_num_o));
        end
        model_step();
        @(posedge clk_i);
        #1;
        check_all();
        if (refill_overrun_o) over_cnt++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic clear_stats();
        acc_total = 0; acc_bytes = 0; over_cnt = 0; rec_q.delete();
        for (int i = 0; i < FLOW_CNT; i++) acc_per_flow[i] = 0;
    endtask

    task automatic clear_writes();
        wr_size_wr_en_i = 0; wr_token_wr_en_i = 0; wr_flow_en_wr_en_i = 0;
    endtask

    task automatic cfg(input int f, input int sz, input longint unsigned tok, input bit en);
        wr_size_addr_i  = FLOW_W'(f); wr_size_data_i  = SIZE_W'(sz);   wr_size_wr_en_i  = 1;
        wr_token_addr_i = FLOW_W'(f); wr_token_data_i = TOKEN_W'(tok); wr_token_wr_en_i = 1;
        wr_flow_en_addr_i = FLOW_W'(f); wr_flow_en_data_i = en;        wr_flow_en_wr_en_i = 1;
        cycle();
        clear_writes();
    endtask

    task automatic wait_valid(input int bound, input string tag);
        int n;
        n = 0;
        while (!task_valid_o && n < bound) begin
            cycle();
            n++;
        end
        vectors++;
        if (!task_valid_o) begin
            miscompares++;
            $display("FAIL %s: valid stayed 0 for %0d cycles, expected 1", tag, bound);
        end
    endtask

    task automatic align_tick(input int pos);
        while (m_tick != pos) cycle();
    endtask

    task automatic rand_inputs();
        wr_size_wr_en_i    = ($urandom_range(0, 19) == 0);
        wr_size_addr_i     = FLOW_W'($urandom_range(0, FLOW_CNT - 1));
        wr_size_data_i     = SIZE_W'($urandom_range(0, 150));
        wr_token_wr_en_i   = ($urandom_range(0, 19) == 0);
        wr_token_addr_i    = FLOW_W'($urandom_range(0, FLOW_CNT - 1));
        wr_token_data_i    = TOKEN_W'($urandom_range(0, 400));
        wr_flow_en_wr_en_i = ($urandom_range(0, 24) == 0);
        wr_flow_en_addr_i  = FLOW_W'($urandom_range(0, FLOW_CNT - 1));
        wr_flow_en_data_i  = ($urandom_range(0, 3) != 0);
        task_ready_i       = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int exp_order [6] = '{0, 1, 2, 0, 1, 2};
        int k;
        clear_writes();
        wr_size_addr_i = '0; wr_size_data_i = '0;
        wr_token_addr_i = '0; wr_token_data_i = '0;
        wr_flow_en_addr_i = '0; wr_flow_en_data_i = 0;
        task_ready_i = 0;
        model_reset();
        clear_stats();

        // Reset state.
        @(posedge clk_i);
        #1;
        chk("rst valid", 64'(task_valid_o), 0);
        chk("rst flow", 64'(task_flow_num_o), 0);
        chk("rst size", 64'(task_pkt_size_o), 0);
        chk("rst overrun", 64'(refill_overrun_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 0;

        // Nothing enabled: no tasks, refills keep up so no overruns.
        task_ready_i = 1;
        run(1000);
        chk("idle tasks", 64'(acc_total), 0);
        chk("idle overruns", 64'(over_cnt), 0);

        // One flow, one packet's worth of credit per period.
        align_tick(50);
        cfg(3, 64, 64, 1);
        clear_stats();
        run(300);
        chk("f3 tasks", 64'(acc_per_flow[3]), 3);
        chk("f3 total", 64'(acc_total), 3);
        chk("f3 bytes", 64'(acc_bytes), 192);
        chk("f3 bucket", 64'(dut.bucket_q[3]), 0);
        cfg(3, 64, 64, 0);

        // Three flows with deep credit are served in rotation.
        align_tick(50);
        cfg(0, 10, 10000, 1);
        cfg(1, 10, 10000, 1);
        cfg(2, 10, 10000, 1);
        clear_stats();
        k = 0;
        while (rec_q.size() < 8 && k < 400) begin
            cycle();
            k++;
        end
        chk("rr count", 64'(rec_q.size() >= 8), 1);
        k = -1;
        for (int i = 0; i < 3; i++)
            if (k < 0 && rec_q.size() > i && rec_q[i] == 0) k = i;
        chk("rr start", 64'(k >= 0), 1);
        if (k >= 0)
            for (int j = 0; j < 6; j++)
                chk($sformatf("rr order %0d", j), 64'(rec_q[k + j]), 64'(exp_order[j]));
        cfg(0, 10, 10000, 0);
        cfg(1, 10, 10000, 0);
        cfg(2, 10, 10000, 0);
        run(10);

        // Back-pressure across several periods: offer held, lost ticks flagged.
        task_ready_i = 0;
        cfg(1, 20, 30, 1);
        wait_valid(250, "hold wait");
        chk("hold flow", 64'(task_flow_num_o), 1);
        chk("hold size", 64'(task_pkt_size_o), 20);
        clear_stats();
        run(310);
        chk("hold overruns", 64'(over_cnt), 2);
        chk("hold still valid", 64'(task_valid_o), 1);
        task_ready_i = 1;
        cycle();
        chk("hold deduct", 64'(dut.bucket_q[1]), 10);
        cfg(1, 20, 30, 0);
        run(10);

        // Saturation: large token, zero size so nothing drains it.
        cfg(6, 0, 64'h8000_0000, 1);
        run(320);
        chk("sat bucket", 64'(dut.bucket_q[6]), 64'hFFFF_FFFF);
        cfg(6, 0, 64'h8000_0000, 0);
        run(10);

        // Disable while offered: the offer completes, credit stays cleared.
        task_ready_i = 0;
        cfg(5, 100, 100, 1);
        wait_valid(250, "dis wait");
        chk("dis flow", 64'(task_flow_num_o), 5);
        wr_flow_en_addr_i = FLOW_W'(5); wr_flow_en_data_i = 0; wr_flow_en_wr_en_i = 1;
        cycle();
        clear_writes();
        chk("dis held", 64'(task_valid_o), 1);
        task_ready_i = 1;
        cycle();
        chk("dis bucket", 64'(dut.bucket_q[5]), 0);
        clear_stats();
        run(300);
        chk("dis f5 tasks", 64'(acc_per_flow[5]), 0);

        // Random traffic with a reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                clear_writes();
                rst_i = 1;
                #1;
                chk("mid rst valid", 64'(task_valid_o), 0);
                chk("mid rst flow", 64'(task_flow_num_o), 0);
                chk("mid rst overrun", 64'(refill_overrun_o), 0);
                chk("mid rst bucket0", 64'(dut.bucket_q[0]), 0);
                @(posedge clk_i);
                #1;
                rst_i = 0;
                model_reset();
            end
            rand_inputs();
            cycle();
        end
        clear_writes();
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pkt_gen_token_scheduler.md
# pkt_gen_token_scheduler

Parametrised token-bucket scheduler for the multiflow packet generator. It keeps one byte-credit bucket per flow and refills every bucket with its configured token amount every UPDATE_PERIOD cycles. It scans the enabled flows round-robin and emits one task (flow number, packet size) per eligible flow over a valid/ready handshake into the task FIFO. Compared with the previous engine it adds configurable widths, bucket saturation, per-flow enable gating with bucket clear, round-robin fairness, a held-stable task handshake and refill-overrun reporting.

## Interface
- FLOW_CNT, 16: number of flows, ≥1
- SIZE_W, 16: packet-size width in bytes
- TOKEN_W, 32: per-period token width
- BUCKET_W, 32: bucket width, ≥ max(SIZE_W, TOKEN_W)
- UPDATE_PERIOD, 100: refill interval in cycles, must be ≥ FLOW_CNT+2
- FLOW_W, derived: 1 if FLOW_CNT==1, else $clog2(FLOW_CNT)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- wr_size_addr_i / wr_size_data_i / wr_size_wr_en_i  in  FLOW_W/SIZE_W/1  per-flow packet size write
- wr_token_addr_i / wr_token_data_i / wr_token_wr_en_i  in  FLOW_W/TOKEN_W/1  per-flow token write
- wr_flow_en_addr_i / wr_flow_en_data_i / wr_flow_en_wr_en_i  in  FLOW_W/1/1  flow enable write
- task_flow_num_o  out  FLOW_W  flow of the offered task
- task_pkt_size_o  out  SIZE_W  size of the offered task
- task_valid_o  out  1  task offered
- task_ready_i  in  1  task FIFO accepts
- refill_overrun_o  out  1  one-cycle pulse when an update tick is lost

## Operation
- Storage: per-flow registers size[], token[], bucket[], en[]. All are 0 after reset.
- Tick counter: counts 0..UPDATE_PERIOD-1 and wraps. A wrap sets refill_pend.
- If refill_pend is already set when the next tick arrives, the tick is dropped and refill_overrun_o pulses.
- FSM states: SCAN, EMIT, REFILL.
- SCAN → REFILL when refill_pend is set. Refill has priority over the scan. refill_pend clears on entry and ridx=0.
- SCAN, no refill pending: examine flow ptr. Flow is eligible when en[ptr]=1, size[ptr]≠0 and bucket[ptr] ≥ size[ptr].
  - Eligible: latch flow and size, go to EMIT.
  - Not eligible: ptr = ptr+1, wrapping at FLOW_CNT-1 → 0.
- EMIT: task_valid_o=1. Flow and size stay stable until task_ready_i. On valid&&ready:
  - bucket[flow] -= latched size
  - ptr = flow+1 (wrapped)
  - go to SCAN
  - Ticks during EMIT only set refill_pend.
- REFILL: one flow per cycle, ridx 0..FLOW_CNT-1. bucket[ridx] = min(bucket+token, 2^BUCKET_W-1), with the sum computed at BUCKET_W+1 bits. Disabled flows are skipped. After the last flow, go to SCAN; ptr is unchanged.
- Config writes take effect the next cycle. Size and token changes never affect a task already latched.
- Writing en=0 clears bucket[addr] the same cycle. The clear beats any concurrent refill or deduct to that flow.
- An already-offered task is never retracted, even if its flow is disabled.
- No underflow is possible: between check and deduct the bucket can only be cleared, never refilled.
- Reset mid-operation: everything returns to reset state and any offered task is dropped.

## Timing
- Reset values: task_valid_o=0, task_flow_num_o=0, task_pkt_size_o=0, refill_overrun_o=0. FSM=SCAN, ptr=0, tick=0.
- Eligibility found in SCAN cycle N → task_valid_o=1 in cycle N+1.
- Handshake accepted in cycle M → bucket updated at M+1. The earliest next task_valid_o is M+2.
- A refill pass occupies FLOW_CNT cycles. Its first update is one cycle after the tick if the FSM is in SCAN.
- Worst case, FLOW_CNT flows eligible and ready held high: one task every 2 cycles.

## Structure
- Package pkt_gen_pkg: FSM state enum, and a flow_num_t typedef sized by FLOW_W.
- Sub-module pkt_gen_tick_gen: the period counter plus refill_pend/overrun logic, parametrised by UPDATE_PERIOD.

## Test plan
- Reset → all outputs 0; no task appears while no flow is enabled, over 1000 cycles.
- Flow 3: size=64, token=64, enabled, ready=1 → exactly one task per period, flow 3, size 64; bucket returns to 0.
- Flows 0, 1, 2 all eligible with large buckets, ready=1 → tasks issued in order 0, 1, 2, 0, 1, 2.
- Hold ready=0 for 300 cycles with period 100 → task stays stable; two refill_overrun_o pulses; correct deduct after ready.
- Token=2^31, BUCKET_W=32, 3 periods with no emission → bucket saturates at 0xFFFFFFFF.
- Disable flow 5 while its task is offered → the task completes on ready, then bucket[5]=0 and no further tasks for flow 5.
